// File: rtl/inc_issue_sequencer.sv
// Issues increment strobes to the register-increment decoder: a target mask repeated
// `count` times, either whole-mask per cycle or one target per cycle, with stall/abort.
module inc_issue_sequencer #(
   parameter int SEL_W = 7,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SEL_W-1:0] req_mask,
   input  logic [CNT_W-1:0] req_count,
   input  logic             req_serial,
   input  logic             stall,
   input  logic             abort,
   output logic [SEL_W-1:0] INC_sel,
   output logic             INC_en,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] SEL_ZERO = '0;
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic [SEL_W-1:0] mask_r;
   logic [CNT_W-1:0] count_r;
   logic             serial_r;
   logic [SEL_W-1:0] remaining_r;
   logic             done_r;

   logic [SEL_W-1:0] low_bit;
   logic [SEL_W-1:0] remaining_nxt;
   logic             issue_en;
   logic             accept;

   // Two's-complement trick isolates the lowest set bit of the pending targets.
   assign low_bit       = remaining_r & (~remaining_r + SEL_ONE);
   assign remaining_nxt = remaining_r & ~low_bit;
   assign accept        = req_valid && (state == IDLE);

   // NOTE: every signal written in an always_comb gets a default first, so no path
   // through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      issue_en = 1'b0;
      INC_sel  = SEL_ZERO;
      if (state == ISSUE) begin
         issue_en = !stall && !abort;
         if (issue_en) begin
            INC_sel = serial_r ? low_bit : mask_r;
         end
      end
   end

   assign INC_en    = issue_en;
   assign req_ready = (state == IDLE);
   assign busy      = (state == ISSUE);
   assign done      = done_r;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values and the update order inside the block does not matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mask_r      <= SEL_ZERO;
         count_r     <= CNT_ZERO;
         serial_r    <= 1'b0;
         remaining_r <= SEL_ZERO;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  mask_r      <= req_mask;
                  count_r     <= req_count;
                  serial_r    <= req_serial;
                  remaining_r <= req_mask;
                  if ((req_count == CNT_ZERO) || (req_mask == SEL_ZERO)) begin
                     done_r <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (abort) begin
                  state <= IDLE;
               end else if (!stall) begin
                  if (!serial_r) begin
                     count_r <= count_r - CNT_ONE;
                     if (count_r == CNT_ONE) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                     end
                  end else if (remaining_nxt == SEL_ZERO) begin
                     // One full pass over the mask completes one repetition.
                     count_r     <= count_r - CNT_ONE;
                     remaining_r <= mask_r;
                     if (count_r == CNT_ONE) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                     end
                  end else begin
                     remaining_r <= remaining_nxt;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inc_issue_sequencer.sv
// Directed, table-driven bench for inc_issue_sequencer: one record per clock cycle
// holding that cycle's inputs and the outputs expected before the next rising edge.
module tb_inc_issue_sequencer;

   localparam int SEL_W = 7;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [SEL_W-1:0] req_mask;
   logic [CNT_W-1:0] req_count;
   logic             req_serial;
   logic             stall;
   logic             abort;
   logic [SEL_W-1:0] INC_sel;
   logic             INC_en;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_fail   = 0;

   inc_issue_sequencer #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mask  (req_mask),
      .req_count (req_count),
      .req_serial(req_serial),
      .stall     (stall),
      .abort     (abort),
      .INC_sel   (INC_sel),
      .INC_en    (INC_en),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            name;
      logic             valid;
      logic [SEL_W-1:0] mask;
      logic [CNT_W-1:0] cnt;
      logic             ser;
      logic             stl;
      logic             abt;
      logic             exp_en;
      logic [SEL_W-1:0] exp_sel;
      logic             exp_done;
      logic             exp_ready;
      logic             exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input string name, input logic valid, input logic [SEL_W-1:0] mask,
                      input logic [CNT_W-1:0] cnt, input logic ser, input logic stl,
                      input logic abt, input logic en, input logic [SEL_W-1:0] sel,
                      input logic dn, input logic rdy, input logic bsy);
      vec_t v;
      v.name = name; v.valid = valid; v.mask = mask; v.cnt = cnt; v.ser = ser;
      v.stl = stl; v.abt = abt; v.exp_en = en; v.exp_sel = sel; v.exp_done = dn;
      v.exp_ready = rdy; v.exp_busy = bsy;
      vecs.push_back(v);
   endtask

   // Accept cycle from IDLE; exp_done set when the previous request completes this cycle.
   task automatic req(input string name, input logic [SEL_W-1:0] mask,
                      input logic [CNT_W-1:0] cnt, input logic ser, input logic dn);
      add(name, 1'b1, mask, cnt, ser, 1'b0, 1'b0, 1'b0, '0, dn, 1'b1, 1'b0);
   endtask

   task automatic strobe(input string name, input logic [SEL_W-1:0] sel);
      add(name, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, sel, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic done_cyc(input string name);
      add(name, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic idle_cyc(input string name, input logic abt);
      add(name, 1'b0, '0, '0, 1'b0, 1'b0, abt, 1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic drive(input logic valid, input logic [SEL_W-1:0] mask,
                        input logic [CNT_W-1:0] cnt, input logic ser,
                        input logic stl, input logic abt);
      req_valid = valid; req_mask = mask; req_count = cnt; req_serial = ser;
      stall = stl; abort = abt;
   endtask

   task automatic check_outputs(input string tag, input logic en, input logic [SEL_W-1:0] sel,
                                input logic dn, input logic rdy, input logic bsy);
      check({tag, ".INC_en"},    32'(INC_en),    32'(en));
      check({tag, ".INC_sel"},   32'(INC_sel),   32'(sel));
      check({tag, ".done"},      32'(done),      32'(dn));
      check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
      check({tag, ".busy"},      32'(busy),      32'(bsy));
   endtask

   initial begin
      // Parallel burst: mask 0000011 x3.
      req("par_acc", 7'b0000011, 4'd3, 1'b0, 1'b0);
      strobe("par_s1", 7'b0000011);
      strobe("par_s2", 7'b0000011);
      strobe("par_s3", 7'b0000011);
      done_cyc("par_done");
      idle_cyc("par_idle", 1'b0);
      // Serial burst: mask 0101001 x2, lowest bit first, mask reloaded between passes.
      req("ser_acc", 7'b0101001, 4'd2, 1'b1, 1'b0);
      strobe("ser_s1", 7'b0000001);
      strobe("ser_s2", 7'b0001000);
      strobe("ser_s3", 7'b0100000);
      strobe("ser_s4", 7'b0000001);
      strobe("ser_s5", 7'b0001000);
      strobe("ser_s6", 7'b0100000);
      done_cyc("ser_done");
      idle_cyc("ser_idle", 1'b0);
      // Stall on the second ISSUE cycle holds the pending target.
      req("stl_acc", 7'b0000110, 4'd1, 1'b1, 1'b0);
      strobe("stl_s1", 7'b0000010);
      add("stl_gap", 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      strobe("stl_s2", 7'b0000100);
      done_cyc("stl_done");
      // Degenerate requests complete without strobes; second accepted in the done cycle.
      req("deg_cnt0", 7'h7F, 4'd0, 1'b0, 1'b0);
      req("deg_mask0", 7'h00, 4'd5, 1'b0, 1'b1);
      done_cyc("deg_done2");
      idle_cyc("deg_idle", 1'b0);
      // Abort (with stall also high) after 4 strobes: no done.
      req("abt_acc", 7'b1000001, 4'd10, 1'b0, 1'b0);
      strobe("abt_s1", 7'b1000001);
      strobe("abt_s2", 7'b1000001);
      strobe("abt_s3", 7'b1000001);
      strobe("abt_s4", 7'b1000001);
      add("abt_cyc", 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      idle_cyc("abt_after", 1'b0);
      idle_cyc("abt_in_idle", 1'b1);
      // Back-to-back: second request accepted in the done cycle.
      req("b2b_acc1", 7'b0010000, 4'd1, 1'b0, 1'b0);
      strobe("b2b_s1", 7'b0010000);
      req("b2b_acc2", 7'b0000100, 4'd2, 1'b0, 1'b1);
      strobe("b2b_s2", 7'b0000100);
      strobe("b2b_s3", 7'b0000100);
      done_cyc("b2b_done");
      idle_cyc("b2b_idle", 1'b0);

      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_outputs("reset", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].valid, vecs[i].mask, vecs[i].cnt, vecs[i].ser, vecs[i].stl, vecs[i].abt);
         #1;
         check_outputs(vecs[i].name, vecs[i].exp_en, vecs[i].exp_sel, vecs[i].exp_done,
                       vecs[i].exp_ready, vecs[i].exp_busy);
      end

      // Reset asserted mid-burst: strobe must drop at once and not resume after release.
      @(negedge clk);
      drive(1'b1, 7'h7F, 4'd10, 1'b0, 1'b0, 1'b0);
      #1;
      check_outputs("rst_acc", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      check_outputs("rst_s1", 1'b1, 7'h7F, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      check_outputs("rst_s2", 1'b1, 7'h7F, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check_outputs("rst_mid", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check_outputs("rst_after", 1'b0, '0, 1'b0, 1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
